keypad_scanner: RTL and testbench

Column-strobing scanner and decoder for the lock's 4x4 matrix keypad. It drives the keypad columns, samples the rows, debounces each press and emits one key code per physical press. It sits between the keypad pins and the lock/display logic, which consume `key_code`/`key_valid`.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_scanner_sync2.sv | 22 ++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } kp_state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row r / column c to key code.
  function automatic logic [3:0] kp_decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Index of the lowest active-low row; only meaningful when some row is low.
  function automatic logic [1:0] kp_lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// 4-bit two-flop synchronizer; resets to all-ones (no key pressed).
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Two-stage capture of the asynchronous row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-strobing 4x4 keypad scanner with per-press debounce.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating columns, waiting for any row low on a tick
// DEBOUNCE | column held, counting consecutive ticks with row r low
// PRESSED  | key accepted, column held, counting idle ticks to release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DWELL_CYCLES     = 50_000,
  parameter int DEBOUNCE_SAMPLES = 10
) (
  input  logic       pulse_50Mhz,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int DBW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CW-1:0]  DWELL_TC = CW'(DWELL_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_TC   = DBW'(DEBOUNCE_SAMPLES);
  localparam logic [DBW-1:0] DEB_ONE  = DBW'(1);

  logic [3:0]     row_s;
  logic [CW-1:0]  dwell_cnt;
  logic [DBW-1:0] deb_cnt;
  logic [DBW-1:0] deb_next;
  logic [1:0]     col_idx;
  logic [1:0]     row_idx;
  logic [1:0]     row_lo;
  logic           tick;
  kp_state_t      state;

  sync2 u_sync2 (
    .clk   (pulse_50Mhz),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign tick     = (dwell_cnt == DWELL_TC);
  assign deb_next = deb_cnt + DEB_ONE;
  assign row_lo   = kp_lowest_low(row_s);
  assign col      = ~(4'b0001 << col_idx);

  // Dwell timer: one sampling tick every DWELL_CYCLES cycles.
  always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
    if (!rst_n)    dwell_cnt <= '0;
    else if (tick) dwell_cnt <= '0;
    else           dwell_cnt <= dwell_cnt + 1'b1;
  end

  // Scan / debounce / release FSM with registered key outputs.
  always_ff @(posedge pulse_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (&row_s) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              row_idx <= row_lo;
              // A single-sample debounce accepts on the detecting tick itself.
              if (DEB_TC == DEB_ONE) begin
                key_code  <= kp_decode(row_lo, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                state     <= PRESSED;
              end else begin
                deb_cnt <= DEB_ONE;
                state   <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!row_s[row_idx]) begin
              if (deb_next == DEB_TC) begin
                key_code  <= kp_decode(row_idx, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                deb_cnt   <= '0;
                state     <= PRESSED;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end
          PRESSED: begin
            // Any low row, including a second key, restarts the release count.
            if (&row_s) begin
              if (deb_next == DEB_TC) begin
                key_held <= 1'b0;
                deb_cnt  <= '0;
                col_idx  <= col_idx + 2'd1;
                state    <= SCAN;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
            end
          end
          default: begin
            deb_cnt <= '0;
            state   <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

  localparam int DWELL = 8;
  localparam int DEB   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] keys [4];

  int errors = 0;
  int checks = 0;
  int ph;
  int strobes = 0;
  int base;

  keypad_scanner #(
    .DWELL_CYCLES     (DWELL),
    .DEBOUNCE_SAMPLES (DEB)
  ) dut (
    .pulse_50Mhz (clk),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

  always #5 clk = ~clk;

  // Keypad: row r pulled low when a pressed key in row r sits on the driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r] & ~col);
  end

  // Cycle phase since reset release; dwell tick lands when ph moves to a multiple of 8.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 0;
    else        ph <= ph + 1;
  end

  // Strobe counter: counts every cycle key_valid is high.
  always @(negedge clk) begin
    if (key_valid === 1'b1) strobes <= strobes + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic to_mid();
    do step(); while ((ph % DWELL) != 4);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * DWELL) step();
  endtask

  task automatic wait_strobe(input string tag, input int b);
    int n = 0;
    while (strobes == b && n < 400) begin
      step();
      n++;
    end
    check(tag, 8'(strobes - b), 8'd1);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
  endtask

  initial begin
    release_all();
    repeat (3) step();
    check("rst_col", col, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);

    // Column rotation, one step per 8 cycles.
    rst_n = 1'b1;
    repeat (7) step();
    check("rot_hold", col, 4'b1110);
    step();
    check("rot_c1", col, 4'b1101);
    repeat (8) step();
    check("rot_c2", col, 4'b1011);
    repeat (8) step();
    check("rot_c3", col, 4'b0111);
    repeat (8) step();
    check("rot_c0", col, 4'b1110);

    // Single press r1c2.
    to_mid();
    base = strobes;
    keys[1][2] = 1'b1;
    wait_strobe("p6_strobe", base);
    check("p6_valid_hi", key_valid, 1'b1);
    check("p6_code", key_code, 4'h6);
    check("p6_held", key_held, 1'b1);
    step();
    check("p6_valid_lo", key_valid, 1'b0);
    wait_ticks(10);
    check("p6_once", 8'(strobes - base), 8'd1);
    check("p6_col_held", col, 4'b1011);
    to_mid();
    release_all();
    wait_ticks(2);
    check("p6_held_2idle", key_held, 1'b1);
    wait_ticks(1);
    check("p6_released", key_held, 1'b0);
    check("p6_col_resume", col, 4'b0111);

    // Bounce on r3c0.
    wait_ticks(1);
    check("b_col0", col, 4'b1110);
    base = strobes;
    keys[3][0] = 1'b1;
    wait_ticks(2);
    check("b_no_strobe", 8'(strobes - base), 8'd0);
    release_all();
    wait_ticks(1);
    check("b_abort_col", col, 4'b1101);
    check("b_abort_nostrobe", 8'(strobes - base), 8'd0);
    keys[3][0] = 1'b1;
    wait_ticks(8);
    check("b_one_strobe", 8'(strobes - base), 8'd1);
    check("b_code", key_code, 4'hE);
    check("b_held", key_held, 1'b1);
    release_all();
    wait_ticks(4);
    check("b_released", key_held, 1'b0);

    // Two keys in one column, then a key in another column while held.
    base = strobes;
    keys[0][3] = 1'b1;
    keys[2][3] = 1'b1;
    wait_strobe("two_strobe", base);
    check("two_code", key_code, 4'hA);
    to_mid();
    keys[0][0] = 1'b1;
    wait_ticks(8);
    check("two_no_second", 8'(strobes - base), 8'd1);
    check("two_code_kept", key_code, 4'hA);
    check("two_still_held", key_held, 1'b1);
    release_all();
    to_mid();
    wait_ticks(4);
    check("two_released", key_held, 1'b0);

    // Release glitch on r2c1.
    base = strobes;
    keys[2][1] = 1'b1;
    wait_strobe("g_strobe", base);
    check("g_code", key_code, 4'h8);
    to_mid();
    release_all();
    wait_ticks(2);
    check("g_held_open2", key_held, 1'b1);
    keys[2][1] = 1'b1;
    wait_ticks(1);
    check("g_held_close1", key_held, 1'b1);
    release_all();
    wait_ticks(2);
    check("g_held_open2b", key_held, 1'b1);
    wait_ticks(1);
    check("g_released", key_held, 1'b0);
    check("g_single_strobe", 8'(strobes - base), 8'd1);

    // Reset pulse while r3c1 is held.
    base = strobes;
    keys[3][1] = 1'b1;
    wait_strobe("r_strobe", base);
    check("r_code", key_code, 4'h0);
    to_mid();
    check("r_held_pre", key_held, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r_async_col", col, 4'b1110);
    check("r_async_held", key_held, 1'b0);
    check("r_async_valid", key_valid, 1'b0);
    check("r_async_code", key_code, 4'h0);
    step();
    step();
    rst_n = 1'b1;
    base = strobes;
    wait_strobe("r_restrike", base);
    check("r_restrike_code", key_code, 4'h0);
    check("r_restrike_held", key_held, 1'b1);
    wait_ticks(6);
    check("r_restrike_once", 8'(strobes - base), 8'd1);
    release_all();
    wait_ticks(4);
    check("r_released", key_held, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
